// File: rtl/inst_fetch_queue.sv
// Instruction prefetch FIFO between instruction fetch and decode; flush empties it.
// Define FETCHQ_BYPASS_EN to let a word pass straight through an empty queue in the same cycle.
module inst_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic [31:0]                push_inst,
   input  logic [31:0]                push_pc,
   output logic                       pop_valid,
   input  logic                       pop_ready,
   output logic [31:0]                pop_inst,
   output logic [31:0]                pop_pc,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [CW-1:0] occ;

   logic queue_empty;
   logic bypass_active;
   logic bypass_take;
   logic push_fire;
   logic pop_fire;
   logic write_en;
   logic read_en;

   assign queue_empty = (occ == '0);
   assign push_ready  = (occ != FULL_COUNT) && !flush;
   assign push_fire   = push_valid && push_ready;
   assign pop_fire    = pop_valid && pop_ready;
   assign count       = occ;

`ifdef FETCHQ_BYPASS_EN
   // An empty queue forwards the incoming word; if decode takes it, it is never stored.
   assign bypass_active = queue_empty && push_valid && !flush;
`else
   assign bypass_active = 1'b0;
`endif
   assign bypass_take = bypass_active && pop_ready;

   assign write_en = push_fire && !bypass_take;
   assign read_en  = pop_fire && !bypass_take;

   always_comb begin
      pop_valid = 1'b0;
      pop_inst  = NOP_INST;
      pop_pc    = '0;
      if (!queue_empty) begin
         pop_valid = 1'b1;
         pop_inst  = mem[rp][31:0];
         pop_pc    = mem[rp][63:32];
      end else if (bypass_active) begin
         pop_valid = 1'b1;
         pop_inst  = push_inst;
         pop_pc    = push_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wp  <= '0;
         rp  <= '0;
         occ <= '0;
      end else begin
         if (write_en) wp <= wp + 1'b1;
         if (read_en)  rp <= rp + 1'b1;
         occ <= occ + CW'(write_en) - CW'(read_en);
      end
   end

   // Entry contents need no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (!rst && !flush && write_en) mem[wp] <= {push_pc, push_inst};
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_inst_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] NOP_INST = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst, flush, push_valid, push_ready, pop_valid, pop_ready;
   logic [31:0] push_inst, push_pc, pop_inst, pop_pc;
   logic [$clog2(DEPTH):0] count;

   int checks = 0;
   int errors = 0;
   logic [63:0] model_q [$];
   logic [31:0] next_pc = 32'h0;

   inst_fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP_INST)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .push_valid(push_valid), .push_ready(push_ready),
      .push_inst(push_inst), .push_pc(push_pc),
      .pop_valid(pop_valid), .pop_ready(pop_ready),
      .pop_inst(pop_inst), .pop_pc(pop_pc), .count(count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Drive one cycle of inputs, compare outputs with the model, then advance the model.
   task automatic applyStimulus(input logic r, input logic f, input logic pv,
                                input logic [31:0] inst, input logic [31:0] pc, input logic pr);
      logic        byp;
      logic        exp_valid;
      logic [31:0] exp_inst, exp_pc;
      logic        exp_pready;
      @(negedge clk);
      rst = r; flush = f; push_valid = pv; push_inst = inst; push_pc = pc; pop_ready = pr;
      #1;
      byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
      byp = (model_q.size() == 0) && pv && !f;
`endif
      exp_valid = (model_q.size() != 0) || byp;
      if (model_q.size() != 0) begin
         exp_pc   = model_q[0][63:32];
         exp_inst = model_q[0][31:0];
      end else if (byp) begin
         exp_pc   = pc;
         exp_inst = inst;
      end else begin
         exp_pc   = 32'h0;
         exp_inst = NOP_INST;
      end
      exp_pready = (model_q.size() < DEPTH) && !f;
      checkOutput("pop_valid", 64'(pop_valid), 64'(exp_valid));
      checkOutput("pop_inst", 64'(pop_inst), 64'(exp_inst));
      checkOutput("pop_pc", 64'(pop_pc), 64'(exp_pc));
      checkOutput("push_ready", 64'(push_ready), 64'(exp_pready));
      checkOutput("count", 64'(count), 64'(model_q.size()));
      if (r || f) begin
         model_q.delete();
      end else if (byp && pr) begin
         // consumed straight through, nothing stored
      end else begin
         if (model_q.size() != 0 && pr) void'(model_q.pop_front());
         if (exp_pready && pv) model_q.push_back({pc, inst});
      end
   endtask

   task automatic pushWord(input logic [31:0] inst, input logic pr);
      applyStimulus(1'b0, 1'b0, 1'b1, inst, next_pc, pr);
      next_pc += 32'h4;
   endtask

   initial begin
      logic [31:0] fill_insts [4];
      fill_insts[0] = 32'h00500093;
      fill_insts[1] = 32'h00A00113;
      fill_insts[2] = 32'h002081B3;
      fill_insts[3] = 32'hFE0006E3;

      rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
      push_inst = '0; push_pc = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_pop_valid", 64'(pop_valid), 64'd0);
      checkOutput("rst_pop_inst", 64'(pop_inst), 64'h13);
      checkOutput("rst_pop_pc", 64'(pop_pc), 64'd0);
      checkOutput("rst_count", 64'(count), 64'd0);
      checkOutput("rst_push_ready", 64'(push_ready), 64'd1);

      // Fill with decode stalled, refuse a fifth word, then drain in order.
      next_pc = 32'h0;
      for (int i = 0; i < 4; i++) pushWord(fill_insts[i], 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h10, 1'b0);
      checkOutput("full_count", 64'(count), 64'd4);
      checkOutput("full_push_ready", 64'(push_ready), 64'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
         checkOutput("drain_pc", 64'(pop_pc), 64'(i * 4));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      // Wrap-around with occupancy held at two.
      next_pc = 32'h40;
      pushWord(32'h11111111, 1'b0);
      pushWord(32'h22222222, 1'b0);
      for (int i = 0; i < 4; i++) pushWord(32'hA0000000 + i, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

      // Full queue with simultaneous pop: push refused, count drops to three.
      for (int i = 0; i < 4; i++) pushWord(32'hB0000000 + i, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hC0FFEE00, next_pc, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("full_pop_count", 64'(count), 64'd3);

      // Flush with three entries and a pending push, then a push at 0x100.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) pushWord(32'hD0000000 + i, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hE0000000, 32'hFC, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000513, 32'h100, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("flush_push_pc", 64'(pop_pc), 64'h100);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      // Empty queue with push and pop in the same cycle.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h00100513, 32'h20, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      // Random traffic.
      next_pc = 32'h1000;
      for (int i = 0; i < 600; i++) begin
         logic r, f, pv, pr;
         r  = ($urandom_range(99) < 1);
         f  = ($urandom_range(99) < 4);
         pv = ($urandom_range(99) < 60);
         pr = ($urandom_range(99) < 50);
         applyStimulus(r, f, pv, $urandom, next_pc, pr);
         if (pv) next_pc += 32'h4;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
